operand_serializer: RTL and testbench

Upstream feeder for `binary_stream_adder`. It accepts a pair of WIDTH-bit operands through a valid/ready handshake and shifts them out LSB-first as the adder's `A`/`B` bit streams. It issues a one-cycle carry-clear strobe before each word so consecutive additions stay independent. It also marks every bit slot with frame flags so the downstream collector can delimit results.

---
 rtl/serial_pkg.sv | 14 +
 rtl/operand_serializer.sv | 103 ++++++++++
 tb/tb_operand_serializer.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/serial_pkg.sv
// Shared types for the serial adder datapath (operand serializer, sum collector).
// Holds the serializer state encoding and the default operand width.
// Imported by every block that speaks the LSB-first bit-stream framing.
package serial_pkg;

  localparam int SER_WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    SHIFT
  } ser_state_t;

endpackage

// File: rtl/operand_serializer.sv
// Purpose: accepts an operand pair and streams it LSB-first as A/B bit streams,
//          preceded by a one-cycle carry_clr strobe; frames bits with first/last flags.
// Latency/backpressure: first bit 2 cycles after accept; in_ready only in IDLE or on
//          the last bit of a word, so words chain back-to-back with period WIDTH+1.
// Ports: clk/rst (sync, active-high); in_valid/in_ready/in_a/in_b operand handshake;
//        A/B serial bits; bit_valid/bit_first/bit_last framing; carry_clr; busy.
module operand_serializer
  import serial_pkg::*;
#(
  parameter int WIDTH = SER_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             A,
  output logic             B,
  output logic             bit_valid,
  output logic             bit_first,
  output logic             bit_last,
  output logic             carry_clr,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  ser_state_t       state, state_nxt;
  logic [WIDTH-1:0] sa, sb, sa_nxt, sb_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic             word_end;
  logic             accept;

  // The last bit slot doubles as an accept slot so the next word's CLEAR
  // lands directly after it; ready never looks at in_valid.
  assign word_end = (state == SHIFT) && (cnt == LAST);
  assign in_ready = (state == IDLE) || word_end;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sa    <= '0;
      sb    <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      sa    <= sa_nxt;
      sb    <= sb_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    sa_nxt    = sa;
    sb_nxt    = sb;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          sa_nxt    = in_a;
          sb_nxt    = in_b;
          state_nxt = CLEAR;
        end
      end
      CLEAR: begin
        cnt_nxt   = '0;
        state_nxt = SHIFT;
      end
      SHIFT: begin
        sa_nxt = sa >> 1;
        sb_nxt = sb >> 1;
        if (word_end) begin
          // Counter parks at zero instead of wrapping past WIDTH-1.
          cnt_nxt = '0;
          if (accept) begin
            sa_nxt    = in_a;
            sb_nxt    = in_b;
            state_nxt = CLEAR;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decode straight from flops, so A/B are gated to zero outside SHIFT.
  assign A         = (state == SHIFT) && sa[0];
  assign B         = (state == SHIFT) && sb[0];
  assign bit_valid = (state == SHIFT);
  assign bit_first = (state == SHIFT) && (cnt == '0);
  assign bit_last  = word_end;
  assign carry_clr = (state == CLEAR);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_operand_serializer.sv
module tb_operand_serializer;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         in_valid = 1'b0;
  logic [W-1:0] in_a = '0, in_b = '0;
  logic in_ready, A, B, bit_valid, bit_first, bit_last, carry_clr, busy;

  logic       v4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic r4, A4, B4, bv4, bf4, bl4, cc4, bz4;

  operand_serializer #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .A(A), .B(B), .bit_valid(bit_valid),
    .bit_first(bit_first), .bit_last(bit_last), .carry_clr(carry_clr), .busy(busy)
  );

  operand_serializer #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(v4), .in_ready(r4),
    .in_a(a4), .in_b(b4), .A(A4), .B(B4), .bit_valid(bv4),
    .bit_first(bf4), .bit_last(bl4), .carry_clr(cc4), .busy(bz4)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: a word accepted at the edge ending cycle k owns cycles
  // k+1 (clear) .. k+1+W (last bit); the block is ready again on the last bit.
  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    int           acc;
  } exp_t;

  exp_t q[$];
  exp_t ne;
  int   free_c     = 0;
  int   busy_until = -1;
  int   rst_cnt    = 0;
  bit   chk_en     = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      free_c     = cyc + 1;
      busy_until = cyc;
      rst_cnt++;
      chk_en     = 1'b1;
    end else if (in_valid && cyc >= free_c) begin
      ne.a   = in_a;
      ne.b   = in_b;
      ne.acc = cyc;
      q.push_back(ne);
      free_c     = cyc + 1 + W;
      busy_until = cyc + 1 + W;
    end
    cyc++;
  end

  // Behavioural serial adder downstream: carry zeroed by rst or carry_clr.
  logic add_c = 1'b0;
  always @(posedge clk) begin
    if (rst || carry_clr) add_c <= 1'b0;
    else                  add_c <= (A & B) | (add_c & (A ^ B));
  end

  // Monitor / scoreboard
  exp_t         cur;
  bit           active   = 1'b0;
  int           idx      = 0;
  int           seen_rst = 0;
  logic [W-1:0] sum_bits = '0;

  always @(negedge clk) begin
    if (chk_en) begin
      if (seen_rst != rst_cnt) begin
        seen_rst = rst_cnt;
        active   = 1'b0;
      end
      chk("in_ready", in_ready, cyc >= free_c);
      chk("busy", busy, cyc <= busy_until);
      chk("clr_and_bit", carry_clr & bit_valid, 0);
      if (carry_clr) begin
        chk("word_incomplete", active, 0);
        if (q.size() == 0) begin
          chk("clr_unexpected", carry_clr, 0);
        end else begin
          cur = q.pop_front();
          chk("clr_cycle", cyc, cur.acc + 1);
          active   = 1'b1;
          idx      = 0;
          sum_bits = '0;
        end
      end else if (active && !bit_valid) begin
        chk("stream_gap", bit_valid, 1);
        active = 1'b0;
      end
      if (bit_valid) begin
        if (!active) begin
          chk("bit_unexpected", bit_valid, 0);
        end else begin
          chk("A", A, cur.a[idx]);
          chk("B", B, cur.b[idx]);
          chk("bit_first", bit_first, idx == 0);
          chk("bit_last", bit_last, idx == W - 1);
          chk("bit_cycle", cyc, cur.acc + 2 + idx);
          sum_bits[idx] = A ^ B ^ add_c;
          idx++;
          if (idx == W) begin
            chk("sum", sum_bits, W'(cur.a + cur.b));
            active = 1'b0;
          end
        end
      end else begin
        chk("idle_outs", {A, B, bit_first, bit_last}, 0);
      end
    end
  end

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
    logic r;
    int   n;
    n = 0;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    forever begin
      @(negedge clk);
      r = in_ready;
      @(posedge clk);
      n++;
      if (r) break;
      if (n > 60) begin
        tests++;
        fails++;
        $display("FAIL send_timeout: no in_ready within %0d cycles", n);
        break;
      end
    end
    #1 in_valid = 1'b0;
  endtask

  // {carry_clr, bit_valid, A, B, bit_first, bit_last, in_ready, busy}
  logic [7:0] w4_exp [6];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    w4_exp = '{8'b1000_0001, 8'b0110_1001, 8'b0111_0001,
               8'b0101_0001, 8'b0110_0111, 8'b0000_0010};

    // Reset with a pair offered: must not be accepted.
    rst = 1'b1; in_valid = 1'b1; in_a = 8'h55; in_b = 8'hAA;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0; in_valid = 1'b0;

    // Single 4-bit word
    v4 = 1'b1; a4 = 4'b1011; b4 = 4'b0110;
    @(negedge clk);
    chk("w4_ready_idle", r4, 1);
    @(posedge clk);
    #1 v4 = 1'b0;
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      chk($sformatf("w4_cycle%0d", j + 1), {cc4, bv4, A4, B4, bf4, bl4, r4, bz4}, w4_exp[j]);
    end

    // Back-to-back words
    send(8'hFF, 8'h01);
    send(8'h0F, 8'hF0);

    // Stall: pulse in_valid mid-SHIFT, then a real pair
    send(8'hA5, 8'h3C);
    repeat (3) @(posedge clk);
    #1 in_valid = 1'b1; in_a = 8'h11; in_b = 8'h22;
    @(posedge clk);
    #1 in_valid = 1'b0;
    send(8'h5A, 8'hC3);

    // Reset in the 3rd SHIFT cycle
    send(8'hC3, 8'h5A);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", in_ready, 1);
    chk("post_rst_outs", {A, B, bit_valid, bit_first, bit_last, carry_clr, busy}, 0);

    // End-to-end sums and carry isolation
    send(8'd100, 8'd27);
    send(8'hFF, 8'h01);
    send(8'h00, 8'h00);

    // Randomized traffic with occasional resets
    repeat (400) begin
      @(posedge clk);
      #1;
      in_valid = 1'($urandom);
      in_a     = W'($urandom);
      in_b     = W'($urandom);
      rst      = ($urandom_range(0, 99) == 0);
    end
    @(posedge clk);
    #1 rst = 1'b0; in_valid = 1'b0;

    repeat (W + 4) @(posedge clk);
    @(negedge clk);
    chk("drain_queue", q.size(), 0);
    chk("drain_active", active, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
